// File: rtl/quantser_dp.sv
// Quantizer/serializer datapath: quantizes N signed lanes to a (bwout+1)-bit window and shifts them out MSB-first.
// Optional clipping of overflowing lanes is enabled with the QUANTSER_SAT_EN macro.
module quantser_dp #(
    parameter int N       = 64,
    parameter int BWIN    = 27,
    parameter int BWOUT   = 32,
    parameter int BWBWIN  = $clog2(BWIN),
    parameter int BWBWOUT = $clog2(BWOUT)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 stall,
    input  logic                 load,
    input  logic                 step,
    input  logic [BWBWOUT-1:0]   bwout,
    input  logic [BWBWIN-1:0]    msbidx,
    input  logic [N*BWIN-1:0]    din,
    output logic [N-1:0]         dout,
    output logic                 dout_valid,
    output logic                 busy
);

    // Window x[m -: bwout+1] is placed left-aligned in a BWOUT-bit word; missing low bits are zero.
    function automatic logic [BWOUT-1:0] quantize(
        input logic [BWIN-1:0]    x,
        input logic [BWBWIN-1:0]  msb,
        input logic [BWBWOUT-1:0] bw
    );
        logic [BWBWIN-1:0]       m;
        logic [BWIN+BWOUT-2:0]   wide;
        logic [BWOUT-1:0]        keep;
        logic [BWOUT-1:0]        q;
`ifdef QUANTSER_SAT_EN
        logic                    ovf;
`endif
        m    = (msb > BWBWIN'(BWIN-1)) ? BWBWIN'(BWIN-1) : msb;
        wide = {x, {(BWOUT-1){1'b0}}};
        q    = BWOUT'(wide >> m);
        keep = {BWOUT{1'b1}} << (BWOUT - 1 - int'(bw));
        q    = q & keep;
`ifdef QUANTSER_SAT_EN
        ovf = 1'b0;
        for (int j = 0; j < BWIN; j++) begin
            if (j > int'(m) && x[j] != x[m]) ovf = 1'b1;
        end
        if (ovf) begin
            q = x[BWIN-1] ? (BWOUT'(1) << (BWOUT-1)) : (({BWOUT{1'b1}} >> 1) & keep);
        end
`endif
        return q;
    endfunction

    logic [N-1:0][BWOUT-1:0] sr;
    logic [N-1:0][BWOUT-1:0] sr_load;
    logic [BWBWOUT-1:0]      rem;
    logic                    valid;

    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        sr_load = '0;
        for (int i = 0; i < N; i++) begin
            sr_load[i] = quantize(din[i*BWIN +: BWIN], msbidx, bwout);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sr    <= '0;
            rem   <= '0;
            valid <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                sr    <= sr_load;
                rem   <= bwout;
                valid <= 1'b1;
            end else if (step) begin
                // A step with no bits left is a protocol violation and is ignored.
                if (rem != '0) begin
                    for (int i = 0; i < N; i++) sr[i] <= sr[i] << 1;
                    rem <= rem - 1'b1;
                end
            end else if (rem == '0) begin
                valid <= 1'b0;
            end
        end
    end

    always_comb begin
        dout = '0;
        for (int i = 0; i < N; i++) dout[i] = sr[i][BWOUT-1];
    end

    assign dout_valid = valid;
    assign busy       = valid;

endmodule

// File: doc/quantser_dp.md
Name: quantser_dp

Overview:
Quantizer/serializer datapath sitting directly downstream of the quantser controller in each MVU output path.
- Takes N parallel signed accumulator results.
- Quantizes each lane to a programmable (bwout+1)-bit window selected by msbidx.
- Loads the lanes into per-lane shift registers and emits them MSB-first, one bit per lane per step, on `dout`, qualified by `dout_valid`.
- `load`/`step` come straight from the controller; `stall` is shared with it.

Parameters:
- N, 64, number of parallel lanes.
- BWIN, 27, bitwidth of each signed input lane.
- BWOUT, 32, max output bitwidth; a lane's quantized width is bwout+1 ≤ BWOUT.
- BWBWIN, $clog2(BWIN), width of msbidx.
- BWBWOUT, $clog2(BWOUT), width of bwout.

Ports:
- clk  input  1  clock, all state on rising edge.
- clr  input  1  asynchronous active-high reset.
- stall  input  1  freeze all state; load/step ignored while high.
- load  input  1  capture+quantize din into shift registers.
- step  input  1  shift all lanes left by one bit.
- bwout  input  BWBWOUT  output width minus one; sampled on load.
- msbidx  input  BWBWIN  input bit index mapped to output MSB; sampled on load.
- din  input  N*BWIN  lane i = din[i*BWIN +: BWIN], two's complement.
- dout  output  N  current MSB of each lane's shift register.
- dout_valid  output  1  dout holds a valid serial bit.
- busy  output  1  high while a word is being serialized (= dout_valid).

Behaviour:
- Reset, async on clr=1, no clock needed: shift registers 0, dout=0, dout_valid=0, busy=0, remaining-bit counter rem=0, latched bwout=0. Reset mid-stream aborts the stream immediately.
- Priority each rising edge: clr > stall > load > step.
  - With stall=1, everything holds and dout/dout_valid are unchanged.
  - A load coinciding with stall is dropped, matching the controller, which ignores start under stall.
- Quantization of lane value x on load, with W = bwout+1 and effective index m = min(msbidx, BWIN-1):
  - m ≥ bwout: q = x >>> (m-bwout), i.e. x[m : m-bwout].
  - m < bwout: q = x << (bwout-m), zero-filled LSBs.
  - Overflow: bits of x above m that are not all equal to x[m]. Handling is per Optional Feature.
  - q is placed left-aligned at SR[BWOUT-1 : BWOUT-W]; unused LSBs are 0.
- Load, with stall=0 and load=1:
  - SR ← q for all lanes, rem ← bwout, dout_valid ← 1.
  - Next cycle dout = bit W-1 of q.
  - Load during an active stream restarts it; the old word is discarded.
  - Load and step together: load wins and step is ignored.
- Step, with stall=0, load=0, step=1:
  - If rem ≠ 0: SR ← SR<<1, rem ← rem-1. The next bit appears the following cycle.
  - If rem = 0: no shift (protocol violation, ignored).
- End of stream: with stall=0, load=0, step=0, rem=0 and dout_valid=1, dout_valid ← 0 at the edge. The last bit is therefore presented for exactly one unstalled cycle.
- Latency/throughput:
  - load→first bit: 1 cycle.
  - A word of W bits occupies W unstalled cycles: 1 load plus bwout steps.
  - A back-to-back load on the last-bit cycle gives a gapless stream.
- dout is registered (SR MSB) with no combinational path from inputs.

Optional Feature:
Macro QUANTSER_SAT_EN.
- Defined: lanes that overflow are clipped to the W-bit signed extreme: 0 followed by W-1 ones if x ≥ 0, else 1 followed by W-1 zeros.
- Undefined: no overflow detection; q is the plain truncated bit window (wrap-around). The overflow logic is absent from the netlist.

Test Plan:
Bench uses N=2, BWIN=16, BWOUT=8.
1. Basic window: din lane0=0x0120, lane1=0xFFF0, msbidx=11, bwout=7, load 1 cycle, then 7 steps.
   - lane0: 0,0,0,1,0,0,1,0. lane1: 1,1,1,1,1,1,1,1.
   - dout_valid high exactly 8 cycles, then 0.
2. Overflow, lane0=0x7FFF, lane1=0xF000, msbidx=11, bwout=7.
   - With QUANTSER_SAT_EN: lane0 0x7F, lane1 0x80.
   - Without: lane0 0xFF, lane1 0x00.
3. Left shift: lane0=0x0005, msbidx=3, bwout=7 → 0x50 (0,1,0,1,0,0,0,0). Also msbidx=15, bwout=0 → single bit = sign, dout_valid high 1 cycle.
4. Stall: stall=1 for 2 cycles while the 3rd bit is presented → dout and dout_valid frozen, a load pulsed during the stall is ignored, and the stream resumes with the 4th bit.
5. Restart and back-to-back:
   - Load new word while the 4th bit is shown → next cycle shows the new MSB.
   - Load on the last-bit cycle → no gap in dout_valid.
6. Async reset: assert clr between clock edges mid-stream → dout=0, dout_valid=0 before the next edge; after release, the first step with no load leaves dout=0.
